// File: rtl/enemy_spawn_receiver_pkg.sv
// Shared game-state codes, slot lifecycle encoding and widths for the
// enemy spawn receiver slice.
package enemy_spawn_receiver_pkg;

  localparam logic [2:0] GAME_STATE_IDLE     = 3'd0;
  localparam logic [2:0] GAME_STATE_PLAY     = 3'd1;
  localparam int         DEFAULT_NBR_ENEMIES = 8;
  localparam int         KILL_W              = 8;

  typedef enum logic [1:0] {
    SLOT_IDLE    = 2'd0,
    SLOT_PENDING = 2'd1,
    SLOT_ACTIVE  = 2'd2,
    SLOT_EXPLODE = 2'd3
  } slot_state_e;

endpackage

// File: rtl/enemy_spawn_receiver_if.sv
// Spawn tick / hit request bus into the receiver and the per-slot enemy
// status coming back to the renderer, collision and score logic.
interface enemy_spawn_receiver_if
  import enemy_spawn_receiver_pkg::*;
#(
  parameter int NBR_ENEMIES = DEFAULT_NBR_ENEMIES,
  parameter int Y_WIDTH     = 10
);
  logic [NBR_ENEMIES-1:0]         tick;
  logic [NBR_ENEMIES-1:0]         hit;
  logic [NBR_ENEMIES-1:0]         active;
  logic [NBR_ENEMIES-1:0]         exploding;
  logic [NBR_ENEMIES-1:0]         escape;
  logic [NBR_ENEMIES*Y_WIDTH-1:0] enemy_y;
  logic [KILL_W-1:0]              kill_cnt;

  modport master (
    output tick, hit,
    input  active, exploding, escape, enemy_y, kill_cnt
  );

  modport slave (
    input  tick, hit,
    output active, exploding, escape, enemy_y, kill_cnt
  );
endinterface

// File: rtl/enemy_spawn_receiver_slot.sv
// One enemy slot: spawn request latch, per-frame descent, explosion timer
// and escape detection at the bottom of the screen.
module enemy_spawn_receiver_slot
  import enemy_spawn_receiver_pkg::*;
#(
  parameter int Y_WIDTH        = 10,
  parameter int Y_START        = 0,
  parameter int Y_LIMIT        = 480,
  parameter int SPEED          = 1,
  parameter int EXPLODE_FRAMES = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enb,
  input  logic               frame,
  input  logic               play,
  input  logic               tick,
  input  logic               hit,
  output logic               active,
  output logic               exploding,
  output logic               escape,
  output logic               kill,
  output logic [Y_WIDTH-1:0] y
);

  localparam int CNT_W = (EXPLODE_FRAMES > 1) ? $clog2(EXPLODE_FRAMES) : 1;

  slot_state_e        st_q;
  logic [Y_WIDTH-1:0] y_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               esc_q;
  logic [Y_WIDTH:0]   y_next;

  // One spare bit so the limit compare cannot be fooled by wrap-around.
  assign y_next = {1'b0, y_q} + (Y_WIDTH+1)'(SPEED);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q  <= SLOT_IDLE;
      y_q   <= '0;
      cnt_q <= '0;
      esc_q <= 1'b0;
    end else if (enb) begin
      esc_q <= 1'b0;
      if (!play) begin
        st_q <= SLOT_IDLE;
      end else begin
        case (st_q)
          SLOT_IDLE: begin
            if (tick) st_q <= SLOT_PENDING;
          end
          SLOT_PENDING: begin
            if (frame) begin
              st_q <= SLOT_ACTIVE;
              y_q  <= Y_WIDTH'(Y_START);
            end
          end
          SLOT_ACTIVE: begin
            if (hit) begin
              st_q  <= SLOT_EXPLODE;
              cnt_q <= CNT_W'(EXPLODE_FRAMES - 1);
            end else if (frame) begin
              if (y_next >= (Y_WIDTH+1)'(Y_LIMIT)) begin
                st_q  <= SLOT_IDLE;
                esc_q <= 1'b1;
              end else begin
                y_q <= y_next[Y_WIDTH-1:0];
              end
            end
          end
          SLOT_EXPLODE: begin
            if (frame) begin
              if (cnt_q == '0) st_q <= SLOT_IDLE;
              else             cnt_q <= cnt_q - 1'b1;
            end
          end
          default: st_q <= SLOT_IDLE;
        endcase
      end
    end
  end

  assign active    = (st_q == SLOT_ACTIVE);
  assign exploding = (st_q == SLOT_EXPLODE);
  assign escape    = esc_q & enb;
  assign kill      = enb & play & hit & (st_q == SLOT_ACTIVE);
  assign y         = y_q;

endmodule

// File: rtl/enemy_spawn_receiver.sv
// Consumer of the per-lane spawn tick bus: one enemy slot per lane plus the
// shared saturating kill counter and packed y output.
module enemy_spawn_receiver
  import enemy_spawn_receiver_pkg::*;
#(
  parameter int NBR_ENEMIES    = DEFAULT_NBR_ENEMIES,
  parameter int Y_WIDTH        = 10,
  parameter int Y_START        = 0,
  parameter int Y_LIMIT        = 480,
  parameter int SPEED          = 1,
  parameter int EXPLODE_FRAMES = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enb,
  input  logic                   pixel_0_line_0,
  input  logic [2:0]             state,
  enemy_spawn_receiver_if.slave  bus
);

  localparam int CW = $clog2(NBR_ENEMIES + 1);

  logic                           frame;
  logic                           play;
  logic [NBR_ENEMIES-1:0]         active_v;
  logic [NBR_ENEMIES-1:0]         exploding_v;
  logic [NBR_ENEMIES-1:0]         escape_v;
  logic [NBR_ENEMIES-1:0]         kill_v;
  logic [NBR_ENEMIES*Y_WIDTH-1:0] y_v;
  logic [CW-1:0]                  hit_cnt;
  logic [KILL_W-1:0]              kill_cnt_q;

  function automatic logic [KILL_W-1:0] sat_add(input logic [KILL_W-1:0] a,
                                                input logic [CW-1:0]     b);
    logic [KILL_W:0] s;
    s = {1'b0, a} + (KILL_W+1)'(b);
    return s[KILL_W] ? {KILL_W{1'b1}} : s[KILL_W-1:0];
  endfunction

  assign frame = pixel_0_line_0 & enb;
  assign play  = (state == GAME_STATE_PLAY);

  for (genvar i = 0; i < NBR_ENEMIES; i++) begin : g_slot
    enemy_spawn_receiver_slot #(
      .Y_WIDTH        (Y_WIDTH),
      .Y_START        (Y_START),
      .Y_LIMIT        (Y_LIMIT),
      .SPEED          (SPEED),
      .EXPLODE_FRAMES (EXPLODE_FRAMES)
    ) u_slot (
      .clk       (clk),
      .rst       (rst),
      .enb       (enb),
      .frame     (frame),
      .play      (play),
      .tick      (bus.tick[i]),
      .hit       (bus.hit[i]),
      .active    (active_v[i]),
      .exploding (exploding_v[i]),
      .escape    (escape_v[i]),
      .kill      (kill_v[i]),
      .y         (y_v[i*Y_WIDTH +: Y_WIDTH])
    );
  end

  always_comb begin
    hit_cnt = '0;
    for (int i = 0; i < NBR_ENEMIES; i++) hit_cnt = hit_cnt + CW'(kill_v[i]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      kill_cnt_q <= '0;
    end else if (enb) begin
      if (state == GAME_STATE_IDLE) kill_cnt_q <= '0;
      else                          kill_cnt_q <= sat_add(kill_cnt_q, hit_cnt);
    end
  end

  assign bus.active    = active_v;
  assign bus.exploding = exploding_v;
  assign bus.escape    = escape_v;
  assign bus.enemy_y   = y_v;
  assign bus.kill_cnt  = kill_cnt_q;

endmodule

// File: tb/tb_enemy_spawn_receiver.sv
// Directed bench for enemy_spawn_receiver with hand-computed expectations.
module tb_enemy_spawn_receiver;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enb = 1'b1;
  logic       pixel_0_line_0 = 1'b0;
  logic [2:0] state = 3'd1;
  int         checks = 0;
  int         errors = 0;

  enemy_spawn_receiver_if #(.NBR_ENEMIES(8), .Y_WIDTH(10)) bus ();

  enemy_spawn_receiver dut (
    .clk            (clk),
    .rst            (rst),
    .enb            (enb),
    .pixel_0_line_0 (pixel_0_line_0),
    .state          (state),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic frame_pulse();
    pixel_0_line_0 = 1'b1;
    step();
    pixel_0_line_0 = 1'b0;
  endtask

  initial begin
    bus.tick = '0;
    bus.hit  = '0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_active", 80'(bus.active), 80'h0);
    check("rst_exploding", 80'(bus.exploding), 80'h0);
    check("rst_escape", 80'(bus.escape), 80'h0);
    check("rst_enemy_y", bus.enemy_y, 80'h0);
    check("rst_kill_cnt", 80'(bus.kill_cnt), 80'h0);
    rst = 1'b1;
    step();

    // tick together with a frame only reaches PENDING
    bus.tick = 8'h01;
    pixel_0_line_0 = 1'b1;
    step();
    bus.tick = 8'h00;
    pixel_0_line_0 = 1'b0;
    check("spawn_no_direct_active", 80'(bus.active), 80'h0);
    frame_pulse();
    check("spawn_active", 80'(bus.active), 80'h01);
    check("spawn_y0", 80'(bus.enemy_y[9:0]), 80'd0);
    frame_pulse();
    check("descent_y1", 80'(bus.enemy_y[9:0]), 80'd1);
    repeat (99) frame_pulse();
    check("descent_y100", 80'(bus.enemy_y[9:0]), 80'd100);

    // hit and frame in the same cycle
    bus.hit = 8'h01;
    pixel_0_line_0 = 1'b1;
    step();
    bus.hit = 8'h00;
    pixel_0_line_0 = 1'b0;
    check("hit_exploding", 80'(bus.exploding), 80'h01);
    check("hit_not_active", 80'(bus.active), 80'h00);
    check("hit_y_held", 80'(bus.enemy_y[9:0]), 80'd100);
    check("hit_kill_cnt", 80'(bus.kill_cnt), 80'd1);
    repeat (7) frame_pulse();
    check("explode_after7", 80'(bus.exploding), 80'h01);
    check("explode_y_held", 80'(bus.enemy_y[9:0]), 80'd100);
    frame_pulse();
    check("explode_after8", 80'(bus.exploding), 80'h00);

    // escape of slot 3
    bus.tick = 8'h08;
    step();
    bus.tick = 8'h00;
    frame_pulse();
    repeat (479) frame_pulse();
    check("esc_y479", 80'(bus.enemy_y[39:30]), 80'd479);
    check("esc_pre_active", 80'(bus.active), 80'h08);
    check("esc_pre_escape", 80'(bus.escape), 80'h00);
    frame_pulse();
    check("esc_pulse", 80'(bus.escape), 80'h08);
    check("esc_active_clr", 80'(bus.active), 80'h00);
    check("esc_kill_cnt", 80'(bus.kill_cnt), 80'd1);
    check("esc_y_held", 80'(bus.enemy_y[39:30]), 80'd479);
    step();
    check("esc_one_cycle", 80'(bus.escape), 80'h00);

    // duplicate ticks with slot 2 already live
    bus.tick = 8'h04;
    step();
    bus.tick = 8'h00;
    repeat (3) frame_pulse();
    check("dup_y2_old", 80'(bus.enemy_y[29:20]), 80'd2);
    bus.tick = 8'hFF;
    step();
    step();
    bus.tick = 8'h00;
    check("dup_pending", 80'(bus.active), 80'h04);
    frame_pulse();
    check("dup_active", 80'(bus.active), 80'hFF);
    check("dup_enemy_y", bus.enemy_y, 80'd3 << 20);

    // leaving PLAY drops every slot
    state = 3'd2;
    pixel_0_line_0 = 1'b1;
    step();
    pixel_0_line_0 = 1'b0;
    check("gate_active", 80'(bus.active), 80'h00);
    check("gate_escape", 80'(bus.escape), 80'h00);
    check("gate_kill_hold", 80'(bus.kill_cnt), 80'd1);
    state = 3'd0;
    step();
    check("gate_kill_clear", 80'(bus.kill_cnt), 80'd0);
    state = 3'd1;

    // enable low freezes everything and drops requests
    bus.tick = 8'h20;
    step();
    bus.tick = 8'h00;
    repeat (3) frame_pulse();
    check("enb_pre_y5", 80'(bus.enemy_y[59:50]), 80'd2);
    enb = 1'b0;
    bus.tick = 8'h01;
    bus.hit = 8'h20;
    repeat (3) frame_pulse();
    check("enb_escape_low", 80'(bus.escape), 80'h00);
    bus.tick = 8'h00;
    bus.hit = 8'h00;
    step();
    enb = 1'b1;
    step();
    check("enb_y5_frozen", 80'(bus.enemy_y[59:50]), 80'd2);
    check("enb_hit_ignored", 80'(bus.exploding), 80'h00);
    check("enb_kill_cnt", 80'(bus.kill_cnt), 80'd0);
    frame_pulse();
    check("enb_tick_dropped", 80'(bus.active), 80'h20);
    check("enb_y5_moves", 80'(bus.enemy_y[59:50]), 80'd3);

    // popcount of simultaneous hits
    bus.tick = 8'hFF;
    step();
    bus.tick = 8'h00;
    frame_pulse();
    bus.hit = 8'hFF;
    step();
    bus.hit = 8'h00;
    check("multi_hit_kill", 80'(bus.kill_cnt), 80'd8);
    check("multi_hit_expl", 80'(bus.exploding), 80'hFF);
    repeat (8) frame_pulse();

    // saturation with single hits
    for (int k = 1; k <= 300; k++) begin
      bus.tick = 8'h01;
      step();
      bus.tick = 8'h00;
      frame_pulse();
      bus.hit = 8'h01;
      step();
      bus.hit = 8'h00;
      if (k == 246) check("sat_254", 80'(bus.kill_cnt), 80'd254);
      if (k == 247) check("sat_255", 80'(bus.kill_cnt), 80'd255);
      repeat (8) frame_pulse();
    end
    check("sat_hold", 80'(bus.kill_cnt), 80'd255);

    // asynchronous reset while exploding
    bus.tick = 8'h01;
    step();
    bus.tick = 8'h00;
    frame_pulse();
    bus.hit = 8'h01;
    step();
    bus.hit = 8'h00;
    check("arst_pre_expl", 80'(bus.exploding), 80'h01);
    #2;
    rst = 1'b0;
    #1;
    check("arst_exploding", 80'(bus.exploding), 80'h00);
    check("arst_active", 80'(bus.active), 80'h00);
    check("arst_kill_cnt", 80'(bus.kill_cnt), 80'd0);
    check("arst_enemy_y", bus.enemy_y, 80'h0);
    check("arst_escape", 80'(bus.escape), 80'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/enemy_spawn_receiver.md
Name: enemy_spawn_receiver

Overview:
- Consumer end of the per-lane spawn tick bus. Turns the 8 spawn request pulses into live enemy objects, one slot per lane.
- Each slot runs its own lifecycle: spawn, frame-by-frame descent, kill/explosion, escape at the screen bottom.
- Sits between the spawn controller and the enemy sprite renderer / collision logic. Also feeds the score and lives logic.

Parameters:
- NBR_ENEMIES, 8, number of lanes/slots; must match the spawn tick bus width.
- Y_WIDTH, 10, width of each enemy vertical coordinate.
- Y_START, 0, y loaded on spawn.
- Y_LIMIT, 480, y at or beyond which an enemy has escaped.
- SPEED, 1, pixels of descent per frame.
- EXPLODE_FRAMES, 8, frames a killed enemy stays in explosion.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- enb  in  1  global enable; when low, the whole block freezes
- pixel_0_line_0  in  1  one-cycle frame strobe, first pixel of frame
- state  in  3  game state from the top FSM
- tick  in  NBR_ENEMIES  spawn request pulses, one per lane
- hit  in  NBR_ENEMIES  per-slot bullet collision pulses
- active  out  NBR_ENEMIES  slot holds a live (hittable) enemy
- exploding  out  NBR_ENEMIES  slot is showing an explosion
- enemy_y  out  NBR_ENEMIES*Y_WIDTH  packed y per slot; slot i at bits [i*Y_WIDTH +: Y_WIDTH]
- escape  out  NBR_ENEMIES  one-cycle pulse when slot i escapes
- kill_cnt  out  8  saturating kill counter

Behaviour:
- Reset (rst=0, async): every slot goes to IDLE.
  - active=0, exploding=0, escape=0.
  - enemy_y=0 for all slots, kill_cnt=0.
- frame = pixel_0_line_0 & enb. All movement and expiry happens only on a frame cycle.
- enb=0: no register changes at all. Ticks and hits are ignored, not latched. escape is forced to 0.
- Per-slot FSM states: IDLE, PENDING, ACTIVE, EXPLODE.
  - IDLE:
    - tick[i]=1 goes to PENDING next cycle. This holds even if frame is high in the same cycle; no direct jump to ACTIVE.
  - PENDING:
    - On frame: go to ACTIVE and load y=Y_START.
    - Further ticks are ignored.
  - ACTIVE:
    - hit[i]=1 goes to EXPLODE next cycle. Load the explode counter with EXPLODE_FRAMES-1. Increment kill_cnt, saturating at 255.
    - Else on frame: y_next = y + SPEED, computed at Y_WIDTH+1 bits.
      - If y_next >= Y_LIMIT: go to IDLE, pulse escape[i] for exactly 1 cycle, leave y unchanged.
      - Otherwise store y_next.
    - hit and frame in the same cycle: hit wins. No move, no escape.
    - tick is ignored.
  - EXPLODE:
    - On frame: if counter==0 go to IDLE, else decrement.
    - y is held. hit and tick are ignored.
- Outputs are registered:
  - active = (state==ACTIVE).
  - exploding = (state==EXPLODE).
  - escape = registered pulse.
  - enemy_y is valid only while active or exploding.
- Game state gating: while state != `GAME_STATE_PLAY`, all slots are forced to IDLE on the next cycle and pending requests are dropped.
  - escape stays 0.
  - kill_cnt clears when state == `GAME_STATE_IDLE` and holds otherwise.
- Multiple slots may spawn, escape or be hit in the same cycle. They are fully independent, and kill_cnt adds the popcount of accepted hits, saturating.
- Latency from tick to active=1: one cycle after the first frame strobe that follows the tick.

Decomposition:
- define.v:
  - `GAME_STATE_PLAY` (3'd1) and `GAME_STATE_IDLE` (3'd0).
  - `NBR_ENEMIES`.
  - Slot FSM state encodings (2-bit).
- Sub-module enemy_slot: one FSM, y register, explode counter and escape pulse.
  - Instantiated NBR_ENEMIES times in a generate loop.
  - The top holds the popcount, the saturating kill_cnt and the output packing.

Test Plan:
- Reset then spawn:
  - rst low, then release. Pulse tick=8'h01, then a frame strobe.
  - Required: active=8'h01 the cycle after the strobe, enemy_y[9:0]=0.
  - Each later strobe increments y by 1.
- Escape:
  - Slot 3 active at y=479 with SPEED=1; apply a frame.
  - Required: escape=8'h08 for 1 cycle, active[3]=0, kill_cnt unchanged.
- Hit vs frame collision:
  - Slot 0 active at y=100. Assert hit[0] and frame in the same cycle.
  - Required: exploding[0]=1, y stays 100, kill_cnt +1.
  - exploding[0] clears after exactly 8 further strobes.
- Dropped duplicates:
  - tick=8'hFF twice before a frame, with slot 2 already ACTIVE.
  - Required: after the strobe active=8'hFF, slot 2 y=old+1, all other slots y=0.
- Gating:
  - 4 slots active; set state to a non-PLAY value.
  - Required: active=0 next cycle, escape never pulses.
  - state=`GAME_STATE_IDLE` gives kill_cnt=0.
  - enb=0 for 3 strobes: y values unchanged, and a tick applied in that window is not remembered.
- Saturation:
  - 300 single hits.
  - Required: kill_cnt=255 and it stays there.
  - Asynchronous rst mid-explosion: all outputs 0 immediately, without waiting for a clock edge.
